datapath_pool_scheduler: RTL and testbench

//  Shares a pool of UNITS identical evaluation datapaths among PORTS requesting threads.

---
 rtl/datapath_pool_scheduler_pkg.sv | 20 ++
 rtl/datapath_pool_scheduler_rr_arbiter.sv | 28 ++
 rtl/datapath_pool_scheduler.sv | 152 +++++++++++++++
 tb/tb_datapath_pool_scheduler.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_pool_scheduler_pkg.sv
// Shared constants and types for the datapath pool scheduler.
package datapath_pool_scheduler_pkg;

    localparam int INSTRUCTION_WIDTH = 8;
    localparam int RESULT_WIDTH      = 8;

    // Per-unit lifecycle: ARM drives the start pulse, GUARD masks a stale done level.
    typedef enum logic [1:0] {
        UNIT_IDLE  = 2'd0,
        UNIT_ARM   = 2'd1,
        UNIT_GUARD = 2'd2,
        UNIT_BUSY  = 2'd3
    } unit_state_e;

    // Index width for n items, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/datapath_pool_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, cyclically.
// With ptr tied to zero it degenerates into a lowest-index picker.
module datapath_pool_scheduler_rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx
);

    logic [2*N-1:0] rotated;

    // Rotate the doubled request vector so bit 0 is the port at ptr, then take the first hit.
    always_comb begin
        rotated     = {req, req} >> ptr;
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < N; i++) begin
            if (!grant_valid && rotated[i]) begin
                grant_valid = 1'b1;
                grant_idx   = IDX_W'((int'(ptr) + i) % N);
            end
        end
    end

endmodule

// File: rtl/datapath_pool_scheduler.sv
// Shares UNITS datapaths among PORTS requesting threads. Requests are latched per
// port, granted one per cycle round-robin to the lowest-index idle unit, and each
// unit's result is routed back to the port recorded in its owner tag.
module datapath_pool_scheduler
    import datapath_pool_scheduler_pkg::*;
#(
    parameter int PORTS = 4,
    parameter int UNITS = 2,
    parameter int PID_W = idx_width(PORTS)
) (
    input  logic                           clock,
    input  logic                           resetn,
    input  logic [INSTRUCTION_WIDTH*PORTS-1:0] instruction,
    input  logic [PORTS-1:0]               start,
    output logic [RESULT_WIDTH*PORTS-1:0]  result,
    output logic [PORTS-1:0]               finished,
    output logic [INSTRUCTION_WIDTH*UNITS-1:0] instruction_dp,
    output logic [UNITS-1:0]               start_dp,
    input  logic [RESULT_WIDTH*UNITS-1:0]  result_dp,
    input  logic [UNITS-1:0]               finished_dp,
    output logic [UNITS-1:0]               units_busy
);

    localparam int IW    = INSTRUCTION_WIDTH;
    localparam int RW    = RESULT_WIDTH;
    localparam int UID_W = idx_width(UNITS);

    logic [IW-1:0]       req_q [PORTS];
    logic [IW-1:0]       req_d [PORTS];
    logic [PORTS-1:0]    pending_q, pending_d;
    logic [PORTS-1:0]    finished_q, finished_d;
    logic [RW*PORTS-1:0] result_q, result_d;
    logic [PID_W-1:0]    rr_ptr_q, rr_ptr_d;
    unit_state_e         state_q [UNITS];
    unit_state_e         state_d [UNITS];
    logic [PID_W-1:0]    owner_q [UNITS];
    logic [PID_W-1:0]    owner_d [UNITS];
    logic [IW*UNITS-1:0] instr_dp_q, instr_dp_d;
    logic [UNITS-1:0]    start_dp_q, start_dp_d;

    logic [UNITS-1:0]    unit_idle;
    logic                port_gv, unit_gv;
    logic [PID_W-1:0]    port_gi;
    logic [UID_W-1:0]    unit_gi;

    // Decode which units can accept work and which are occupied.
    always_comb begin
        unit_idle  = '0;
        units_busy = '0;
        for (int u = 0; u < UNITS; u++) begin
            unit_idle[u]  = (state_q[u] == UNIT_IDLE);
            units_busy[u] = (state_q[u] != UNIT_IDLE);
        end
    end

    datapath_pool_scheduler_rr_arbiter #(.N(PORTS), .IDX_W(PID_W)) u_port_arb (
        .req         (pending_q),
        .ptr         (rr_ptr_q),
        .grant_valid (port_gv),
        .grant_idx   (port_gi)
    );

    datapath_pool_scheduler_rr_arbiter #(.N(UNITS), .IDX_W(UID_W)) u_unit_arb (
        .req         (unit_idle),
        .ptr         ({UID_W{1'b0}}),
        .grant_valid (unit_gv),
        .grant_idx   (unit_gi)
    );

    // Next state: request capture, unit FSM advance/retire, then the single dispatch.
    always_comb begin
        req_d      = req_q;
        pending_d  = pending_q;
        finished_d = finished_q;
        result_d   = result_q;
        rr_ptr_d   = rr_ptr_q;
        state_d    = state_q;
        owner_d    = owner_q;
        instr_dp_d = instr_dp_q;
        start_dp_d = '0;

        // A start on a port with work outstanding is dropped; finished_q gates it.
        for (int p = 0; p < PORTS; p++) begin
            if (start[p] && finished_q[p]) begin
                req_d[p]      = instruction[IW*p +: IW];
                pending_d[p]  = 1'b1;
                finished_d[p] = 1'b0;
            end
        end

        // Owners are distinct, so parallel retirements never collide on a port.
        for (int u = 0; u < UNITS; u++) begin
            case (state_q[u])
                UNIT_ARM:   state_d[u] = UNIT_GUARD;
                UNIT_GUARD: state_d[u] = UNIT_BUSY;
                UNIT_BUSY: begin
                    if (finished_dp[u]) begin
                        state_d[u] = UNIT_IDLE;
                        result_d[RW*int'(owner_q[u]) +: RW] = result_dp[RW*u +: RW];
                        finished_d[owner_q[u]] = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        // Units are checked against state_q, so one freed this edge waits a cycle.
        if (port_gv && unit_gv) begin
            state_d[unit_gi]                     = UNIT_ARM;
            owner_d[unit_gi]                     = port_gi;
            instr_dp_d[IW*int'(unit_gi) +: IW]   = req_q[port_gi];
            start_dp_d[unit_gi]                  = 1'b1;
            pending_d[port_gi]                   = 1'b0;
            rr_ptr_d = (port_gi == PID_W'(PORTS - 1)) ? '0 : port_gi + PID_W'(1);
        end
    end

    // State registers; reset abandons in-flight work and parks every unit in IDLE.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            for (int p = 0; p < PORTS; p++) begin
                req_q[p] <= '0;
            end
            for (int u = 0; u < UNITS; u++) begin
                state_q[u] <= UNIT_IDLE;
                owner_q[u] <= '0;
            end
            pending_q  <= '0;
            finished_q <= '1;
            result_q   <= '0;
            rr_ptr_q   <= '0;
            instr_dp_q <= '0;
            start_dp_q <= '0;
        end else begin
            req_q      <= req_d;
            state_q    <= state_d;
            owner_q    <= owner_d;
            pending_q  <= pending_d;
            finished_q <= finished_d;
            result_q   <= result_d;
            rr_ptr_q   <= rr_ptr_d;
            instr_dp_q <= instr_dp_d;
            start_dp_q <= start_dp_d;
        end
    end

    assign result         = result_q;
    assign finished       = finished_q;
    assign instruction_dp = instr_dp_q;
    assign start_dp       = start_dp_q;

endmodule

// File: tb/tb_datapath_pool_scheduler.sv
// Directed bench for datapath_pool_scheduler with a behavioural datapath pool
// and a per-port result scoreboard.
module tb_datapath_pool_scheduler;
    import datapath_pool_scheduler_pkg::*;

    localparam int PORTS = 4;
    localparam int UNITS = 2;
    localparam int IW    = INSTRUCTION_WIDTH;
    localparam int RW    = RESULT_WIDTH;

    logic                clock = 1'b0;
    logic                resetn;
    logic [IW*PORTS-1:0] instruction;
    logic [PORTS-1:0]    start;
    logic [RW*PORTS-1:0] result;
    logic [PORTS-1:0]    finished;
    logic [IW*UNITS-1:0] instruction_dp;
    logic [UNITS-1:0]    start_dp;
    logic [RW*UNITS-1:0] result_dp;
    logic [UNITS-1:0]    finished_dp;
    logic [UNITS-1:0]    units_busy;

    int tests_run    = 0;
    int tests_failed = 0;

    // Scoreboard entry: {port[1:0], expected result[7:0]}.
    logic [9:0]    exp_q[$];
    logic [IW-1:0] disp_log[$];
    logic [PORTS-1:0] prev_fin = '1;

    // Knobs written by the directed sequence, read by the datapath model.
    int   unit_delay [UNITS];
    logic stale_req  [UNITS];

    // Clock/reset block.
    always #5 clock = ~clock;

    datapath_pool_scheduler #(.PORTS(PORTS), .UNITS(UNITS)) dut (
        .clock          (clock),
        .resetn         (resetn),
        .instruction    (instruction),
        .start          (start),
        .result         (result),
        .finished       (finished),
        .instruction_dp (instruction_dp),
        .start_dp       (start_dp),
        .result_dp      (result_dp),
        .finished_dp    (finished_dp),
        .units_busy     (units_busy)
    );

    function automatic logic [7:0] dp_fn(input logic [7:0] x);
        return x ^ 8'hBB;
    endfunction

    // Datapath pool model: finished_dp rises unit_delay ticks after start_dp is seen,
    // for one cycle. A stale request holds finished_dp high from idle through GUARD.
    initial begin : unit_model
        int   cnt        [UNITS];
        logic pulse_on   [UNITS];
        logic stale_take [UNITS];
        logic stale_wait [UNITS];
        int   stale_hold [UNITS];
        logic [IW-1:0] cap [UNITS];
        finished_dp = '0;
        result_dp   = '0;
        for (int u = 0; u < UNITS; u++) begin
            cnt[u] = 0; pulse_on[u] = 1'b0; stale_take[u] = 1'b0;
            stale_wait[u] = 1'b0; stale_hold[u] = 0; cap[u] = '0;
        end
        forever begin
            @(posedge clock);
            #1;
            for (int u = 0; u < UNITS; u++) begin
                if (pulse_on[u]) begin
                    finished_dp[u] = 1'b0;
                    pulse_on[u]    = 1'b0;
                end
                if (stale_req[u] && !stale_take[u]) begin
                    finished_dp[u] = 1'b1;
                    stale_take[u]  = 1'b1;
                    stale_wait[u]  = 1'b1;
                end
                if (stale_hold[u] > 0) begin
                    stale_hold[u]--;
                    if (stale_hold[u] == 0) finished_dp[u] = 1'b0;
                end
                if (cnt[u] > 0) begin
                    cnt[u]--;
                    if (cnt[u] == 0) begin
                        finished_dp[u]         = 1'b1;
                        result_dp[RW*u +: RW]  = dp_fn(cap[u]);
                        pulse_on[u]            = 1'b1;
                    end
                end
                if (start_dp[u]) begin
                    cap[u] = instruction_dp[IW*u +: IW];
                    cnt[u] = unit_delay[u];
                    if (stale_wait[u]) begin
                        stale_hold[u] = 2;
                        stale_wait[u] = 1'b0;
                    end
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Retire the oldest expected result for port p.
    task automatic sb_retire(input int p);
        logic found;
        int   idx;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (!found && exp_q[i][9:8] == 2'(p)) begin
                found = 1'b1;
                idx   = i;
            end
        end
        check($sformatf("sb_expected_port%0d", p), 32'(found), 32'd1);
        if (found) begin
            check($sformatf("sb_result_port%0d", p), 32'(result[RW*p +: RW]), 32'(exp_q[idx][7:0]));
            exp_q.delete(idx);
        end
    endtask

    // Advance one cycle, then log dispatches and score completions.
    task automatic tick();
        @(posedge clock);
        #2;
        for (int u = 0; u < UNITS; u++) begin
            if (start_dp[u]) disp_log.push_back(instruction_dp[IW*u +: IW]);
        end
        for (int p = 0; p < PORTS; p++) begin
            if (resetn && finished[p] && !prev_fin[p]) sb_retire(p);
        end
        prev_fin = finished;
    endtask

    task automatic issue(input int p, input logic [7:0] instr, input logic accept);
        instruction[IW*p +: IW] = instr;
        start[p] = 1'b1;
        if (accept) exp_q.push_back({2'(p), dp_fn(instr)});
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        exp_q.delete();
    endtask

    task automatic wait_all_finished(input string tag, input int budget);
        int n;
        n = 0;
        while (finished !== 4'hF && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(finished), 32'hF);
    endtask

    // Compare dispatch log entries from base against packed bytes (entry i in byte i).
    task automatic check_log(input string tag, input int base, input int n, input logic [31:0] want);
        check({tag, "_count"}, 32'(disp_log.size() - base), 32'(n));
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_%0d", tag, i), 32'(disp_log[base + i]), 32'(want[8*i +: 8]));
        end
    endtask

    initial begin : main
        int base;
        resetn      = 1'b0;
        start       = '0;
        instruction = '0;
        unit_delay  = '{3, 3};
        stale_req   = '{1'b0, 1'b0};

        // Reset state.
        tick();
        tick();
        check("rst_finished", 32'(finished), 32'hF);
        check("rst_start_dp", 32'(start_dp), 32'h0);
        check("rst_result", result, 32'h0);
        check("rst_units_busy", 32'(units_busy), 32'h0);
        check("rst_instruction_dp", 32'(instruction_dp), 32'h0);
        resetn = 1'b1;

        // Single uncontended request: start_dp two cycles after start.
        base = disp_log.size();
        issue(0, 8'h11, 1'b1);
        tick();
        start = '0;
        check("t2_finished_low", 32'(finished), 32'hE);
        check("t2_no_early_start", 32'(start_dp), 32'h0);
        tick();
        check("t2_start_dp", 32'(start_dp), 32'h1);
        check("t2_instr_dp", 32'(instruction_dp[7:0]), 32'h11);
        check("t2_busy", 32'(units_busy), 32'h1);
        repeat (3) tick();
        check("t2_not_done_yet", 32'(finished[0]), 32'h0);
        tick();
        check("t2_finished", 32'(finished), 32'hF);
        check("t2_result", result, 32'h0000_00AA);
        check("t2_idle", 32'(units_busy), 32'h0);
        check_log("t2_log", base, 1, 32'h11);

        // All four ports at once from rr_ptr=0.
        do_reset();
        check("t3_reset_result", result, 32'h0);
        unit_delay = '{5, 5};
        base = disp_log.size();
        issue(0, 8'h20, 1'b1);
        issue(1, 8'h21, 1'b1);
        issue(2, 8'h22, 1'b1);
        issue(3, 8'h23, 1'b1);
        tick();
        start = '0;
        check("t3_all_pending", 32'(finished), 32'h0);
        repeat (8) tick();
        check("t3_unit0_regrant", 32'(start_dp), 32'h1);
        check("t3_unit0_instr", 32'(instruction_dp[7:0]), 32'h22);
        check("t3_first_two_done", 32'(finished), 32'h3);
        tick();
        check("t3_unit1_regrant", 32'(start_dp), 32'h2);
        check("t3_unit1_instr", 32'(instruction_dp[15:8]), 32'h23);
        wait_all_finished("t3_drain", 40);
        check_log("t3_order", base, 4, 32'h2322_2120);
        check("t3_results", result, {dp_fn(8'h23), dp_fn(8'h22), dp_fn(8'h21), dp_fn(8'h20)});

        // Two units completing in the same cycle.
        unit_delay = '{5, 4};
        base = disp_log.size();
        issue(1, 8'h51, 1'b1);
        issue(2, 8'h52, 1'b1);
        tick();
        start = '0;
        repeat (6) tick();
        check("t5_both_outstanding", 32'(finished), 32'h9);
        tick();
        check("t5_both_done", 32'(finished), 32'hF);
        check("t5_results", result, {dp_fn(8'h23), dp_fn(8'h52), dp_fn(8'h51), dp_fn(8'h20)});
        check_log("t5_order", base, 2, 32'h0000_5251);

        // rr_ptr=2 with ports 0 and 3 pending and one unit idle: port 3 first.
        unit_delay = '{12, 3};
        base = disp_log.size();
        issue(1, 8'h61, 1'b1);
        tick();
        start = '0;
        issue(0, 8'h60, 1'b1);
        issue(3, 8'h63, 1'b1);
        tick();
        start = '0;
        check("t4_port1_dispatch", 32'(start_dp), 32'h1);
        check("t4_port1_instr", 32'(instruction_dp[7:0]), 32'h61);
        tick();
        check("t4_port3_first", 32'(start_dp), 32'h2);
        check("t4_port3_instr", 32'(instruction_dp[15:8]), 32'h63);
        wait_all_finished("t4_drain", 40);
        check_log("t4_order", base, 3, 32'h0060_6361);

        // Re-pulse while busy is ignored; a stale done level through GUARD is not completion.
        unit_delay   = '{4, 4};
        stale_req[0] = 1'b1;
        base = disp_log.size();
        tick();
        check("t6_idle_done_ignored", 32'(finished), 32'hF);
        issue(1, 8'h71, 1'b1);
        tick();
        start = '0;
        issue(1, 8'h7F, 1'b0);
        tick();
        start = '0;
        check("t6_dispatch", 32'(start_dp), 32'h1);
        check("t6_original_instr", 32'(instruction_dp[7:0]), 32'h71);
        repeat (2) tick();
        check("t6_guard_stale_ignored", 32'(finished[1]), 32'h0);
        check("t6_unit_still_busy", 32'(units_busy[0]), 32'h1);
        repeat (2) tick();
        check("t6_still_outstanding", 32'(finished[1]), 32'h0);
        issue(1, 8'h80, 1'b0);
        tick();
        start = '0;
        check("t6_done", 32'(finished), 32'hF);
        check("t6_result", 32'(result[15:8]), 32'(dp_fn(8'h71)));
        issue(1, 8'h81, 1'b1);
        tick();
        start = '0;
        check("t6_restart_accepted", 32'(finished[1]), 32'h0);
        wait_all_finished("t6_drain", 30);
        check_log("t6_order", base, 2, 32'h0000_8171);

        // Reset with a unit BUSY; its later done pulse must be ignored.
        unit_delay = '{6, 6};
        issue(2, 8'h90, 1'b1);
        tick();
        start = '0;
        repeat (3) tick();
        check("mid_unit_busy", 32'(units_busy), 32'h1);
        do_reset();
        check("mid_rst_finished", 32'(finished), 32'hF);
        check("mid_rst_start_dp", 32'(start_dp), 32'h0);
        check("mid_rst_result", result, 32'h0);
        check("mid_rst_busy", 32'(units_busy), 32'h0);
        repeat (6) tick();
        check("mid_late_done_finished", 32'(finished), 32'hF);
        check("mid_late_done_result", result, 32'h0);
        check("mid_late_done_busy", 32'(units_busy), 32'h0);

        check("sb_drained", 32'(exp_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Absolute time limit in case a wait misbehaves.
    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: observed=timeout expected=completion");
        $fatal(1, "time limit reached");
    end

endmodule
